// File: rtl/ub_block_serial_sub_64_16.sv
// Block-serial 65-bit minus 16-bit subtractor: one 4-bit borrow-lookahead block per clock,
// optional early exit once X is fully consumed without a pending borrow.
module ub_block_serial_sub_64_16 #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [64:0] S,
    input  logic [15:0] X,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] Y,
    output logic        ERR,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [64:0] s_q, s_d;
    logic [15:0] x_q, x_d;
    logic        b_q, b_d;
    logic [3:0]  k_q, k_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] y_q, y_d;
    logic        err_q, err_d;
    logic        rdy_q, rdy_d;

    logic [3:0]  sk, xk, nx, g, p, yk;
    logic [4:0]  c;
    logic        bo;

    // Borrow look-ahead as the dual of a carry adder: S + ~X + ~b, borrow = ~carry.
    always_comb begin
        sk   = s_q[{k_q, 2'b00} +: 4];
        xk   = (k_q < 4'd4) ? x_q[{k_q[1:0], 2'b00} +: 4] : 4'h0;
        nx   = ~xk;
        g    = sk & nx;
        p    = sk ^ nx;
        c[0] = ~b_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        yk   = p ^ c[3:0];
        bo   = ~c[4];
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        x_d     = x_q;
        b_d     = b_q;
        k_d     = k_q;
        acc_d   = acc_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    s_d     = S;
                    x_d     = X;
                    b_d     = 1'b0;
                    k_d     = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[{k_q, 2'b00} +: 4] = yk;
                b_d = bo;
                k_d = k_q + 4'd1;
                // Partial blocks live in acc_q so Y only ever changes to a complete result.
                if (k_q == 4'd15) begin
                    y_d     = {yk, acc_q[59:0]};
                    err_d   = s_q[64] ^ bo;
                    state_d = DONE;
                end else if (EARLY_EXIT && k_q == 4'd3 && !bo) begin
                    y_d     = {s_q[63:16], yk, acc_q[11:0]};
                    err_d   = s_q[64];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            s_q     <= '0;
            x_q     <= '0;
            b_q     <= 1'b0;
            k_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            x_q     <= x_d;
            b_q     <= b_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q == DONE);
    assign Y         = y_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_ub_block_serial_sub_64_16.sv
// Table + scoreboard bench for the block-serial subtractor (early-exit and full-path instances).
module tb_ub_block_serial_sub_64_16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [64:0] S;
    logic [15:0] X;
    logic        in_valid, out_ready, in_ready, ERR, out_valid;
    logic [63:0] Y;
    logic        in_valid0, out_ready0, in_ready0, ERR0, out_valid0;
    logic [63:0] Y0;

    always #5 CLK = ~CLK;

    ub_block_serial_sub_64_16 #(.EARLY_EXIT(1'b1)) dut (
        .CLK(CLK), .RST(RST), .S(S), .X(X), .in_valid(in_valid), .in_ready(in_ready),
        .Y(Y), .ERR(ERR), .out_valid(out_valid), .out_ready(out_ready));

    ub_block_serial_sub_64_16 #(.EARLY_EXIT(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .S(S), .X(X), .in_valid(in_valid0), .in_ready(in_ready0),
        .Y(Y0), .ERR(ERR0), .out_valid(out_valid0), .out_ready(out_ready0));

    typedef struct {
        logic [64:0] s;
        logic [15:0] x;
        logic [63:0] y;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] y;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic push(input logic [63:0] y, input logic err, input int lat);
        exp_t e;
        e.y = y; e.err = err; e.lat = lat;
        q.push_back(e);
    endtask

    // Called right after an accept edge; returns at the negedge where out_valid is first seen.
    task automatic collect(input string nm);
        int   lat = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (out_valid || lat >= 40) break;
            @(posedge CLK);
            lat++;
        end
        chk({nm, " timeout"}, {63'd0, out_valid}, 64'd1);
        if (q.size() == 0) begin
            chk({nm, " queue"}, 64'd0, 64'd1);
        end else begin
            e = q.pop_front();
            chk({nm, " Y"}, Y, e.y);
            chk({nm, " ERR"}, {63'd0, ERR}, {63'd0, e.err});
            chk({nm, " latency"}, lat, e.lat);
        end
    endtask

    task automatic wait_ready(input string nm);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk({nm, " in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic ack(input string nm);
        out_ready = 1'b1;
        @(posedge CLK);
        #1 out_ready = 1'b0;
        @(negedge CLK);
        chk({nm, " out_valid after ack"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_txn(input logic [64:0] s, input logic [15:0] x,
                           input logic [63:0] ey, input logic eerr, input int elat,
                           input string nm);
        push(ey, eerr, elat);
        @(negedge CLK);
        S = s; X = x; in_valid = 1'b1; out_ready = 1'b0;
        wait_ready(nm);
        @(posedge CLK);
        #1 in_valid = 1'b0;
        collect(nm);
        ack(nm);
    endtask

    vec_t vecs[9];

    initial begin
        logic [63:0] yr;
        logic [15:0] xr;
        logic [64:0] sr;
        int          lat;

        vecs[0] = '{65'h0_0000_0000_0000_1234, 16'h0034, 64'h0000_0000_0000_1200, 1'b0, 4};
        vecs[1] = '{65'h0_0000_0001_0000_0000, 16'h0001, 64'h0000_0000_FFFF_FFFF, 1'b0, 16};
        vecs[2] = '{65'h0_0000_0000_0000_0005, 16'h0006, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16};
        vecs[3] = '{65'h1_0000_0000_0000_0000, 16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 16};
        vecs[4] = '{65'h1_0000_0000_0000_0005, 16'h0001, 64'h0000_0000_0000_0004, 1'b1, 4};
        vecs[5] = '{65'h0_0000_0000_0000_FFFF, 16'hFFFF, 64'h0000_0000_0000_0000, 1'b0, 4};
        vecs[6] = '{65'h1_FFFF_FFFF_FFFF_FFFF, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4};
        vecs[7] = '{65'h0_8000_0000_0000_0000, 16'h0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 16};
        vecs[8] = '{65'h0_DEAD_BEEF_0000_0010, 16'h0011, 64'hDEAD_BEEE_FFFF_FFFF, 1'b0, 16};

        RST = 1'b1; S = '0; X = '0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0;
        #1;
        chk("reset Y", Y, 64'd0);
        chk("reset ERR", {63'd0, ERR}, 64'd0);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset in_ready", {63'd0, in_ready}, 64'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("in_ready after release", {63'd0, in_ready}, 64'd1);

        foreach (vecs[i])
            run_txn(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].err, vecs[i].lat,
                    $sformatf("vec%0d", i));

        // Same early-exit operands on the EARLY_EXIT=0 instance take the full path.
        @(negedge CLK);
        S = 65'h0_0000_0000_0000_1234; X = 16'h0034; in_valid0 = 1'b1;
        chk("ee0 in_ready", {63'd0, in_ready0}, 64'd1);
        @(posedge CLK);
        #1 in_valid0 = 1'b0;
        lat = 0;
        forever begin
            @(negedge CLK);
            if (out_valid0 || lat >= 40) break;
            @(posedge CLK);
            lat++;
        end
        chk("ee0 latency", lat, 16);
        chk("ee0 Y", Y0, 64'h1200);
        chk("ee0 ERR", {63'd0, ERR0}, 64'd0);
        out_ready0 = 1'b1;
        @(posedge CLK);
        #1 out_ready0 = 1'b0;

        // Backpressure: result must hold while in_valid stays high with changing operands.
        push(64'hABCD_0000_0000_0FF0, 1'b0, 4);
        @(negedge CLK);
        S = 65'h0_ABCD_0000_0000_1000; X = 16'h0010; in_valid = 1'b1; out_ready = 1'b0;
        wait_ready("bp");
        @(posedge CLK);
        collect("bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1 S = {1'b0, $urandom(), $urandom()}; X = 16'($urandom());
            @(negedge CLK);
            chk("bp hold Y", Y, 64'hABCD_0000_0000_0FF0);
            chk("bp hold ERR", {63'd0, ERR}, 64'd0);
            chk("bp hold out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp in_ready", {63'd0, in_ready}, 64'd0);
        end
        S = 65'h0_0000_0000_0000_0100; X = 16'h0001;
        push(64'h0000_0000_0000_00FF, 1'b0, 4);
        out_ready = 1'b1;
        @(posedge CLK);
        #1 out_ready = 1'b0;
        @(negedge CLK);
        chk("bp release out_valid", {63'd0, out_valid}, 64'd0);
        chk("bp release in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge CLK);
        #1 in_valid = 1'b0;
        collect("bp pending");
        ack("bp pending");

        // Reset mid-RUN at k=7.
        @(negedge CLK);
        S = 65'h0_0000_0001_0000_0000; X = 16'h0001; in_valid = 1'b1;
        wait_ready("rst");
        @(posedge CLK);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("mid reset Y", Y, 64'd0);
        chk("mid reset ERR", {63'd0, ERR}, 64'd0);
        chk("mid reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid reset in_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("post reset in_ready", {63'd0, in_ready}, 64'd1);
        begin
            int seen = 0;
            repeat (20) begin
                @(negedge CLK);
                if (out_valid) seen++;
            end
            chk("no partial result", seen, 0);
        end
        run_txn(65'h0_0000_0001_0000_0000, 16'h0001, 64'h0000_0000_FFFF_FFFF, 1'b0, 16,
                "after reset");

        // Round trip through the 16+64 adder.
        for (int i = 0; i < 1000; i++) begin
            yr  = {$urandom(), $urandom()};
            xr  = 16'($urandom());
            if (i % 4 == 0) yr[15:0] = 16'($urandom_range(0, 15));
            sr  = {1'b0, yr} + {49'd0, xr};
            lat = (sr[15:0] >= xr) ? 4 : 16;
            run_txn(sr, xr, yr, 1'b0, lat, $sformatf("rt%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
